cmsdk_ahb_to_iop_mc: RTL and testbench

//  Multi-channel AHB-to-IOP bridge: one AHB slave port fanned out to NUM_CH IOP peripherals.

---
 rtl/cmsdk_ahb_to_iop_mc_if.sv | 36 +++
 rtl/cmsdk_ahb_to_iop_mc.sv | 148 ++++++++++++++
 tb/tb_cmsdk_ahb_to_iop_mc.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmsdk_ahb_to_iop_mc_if.sv
// Bus bundle between the AHB slave mux / IOP peripherals and the
// multi-channel AHB-to-IOP bridge. The slave modport is the bridge view,
// the master modport is the view of whatever drives the bridge.
interface cmsdk_ahb_to_iop_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                    HSEL;
  logic                    HREADY;
  logic [1:0]              HTRANS;
  logic [2:0]              HSIZE;
  logic                    HWRITE;
  logic [31:0]             HADDR;
  logic [31:0]             HWDATA;
  logic [NUM_CH*32-1:0]    IORDATA;
  logic [NUM_CH-1:0]       IOREADY;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [31:0]             HRDATA;
  logic [NUM_CH-1:0]       IOSEL;
  logic [ADDR_WIDTH-1:0]   IOADDR;
  logic                    IOWRITE;
  logic [1:0]              IOSIZE;
  logic                    IOTRANS;
  logic [31:0]             IOWDATA;

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, IORDATA, IOREADY,
    output HREADYOUT, HRESP, HRDATA, IOSEL, IOADDR, IOWRITE, IOSIZE, IOTRANS, IOWDATA
  );

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, IORDATA, IOREADY,
    input  HREADYOUT, HRESP, HRDATA, IOSEL, IOADDR, IOWRITE, IOSIZE, IOTRANS, IOWDATA
  );
endinterface

// File: rtl/cmsdk_ahb_to_iop_mc.sv
// Multi-channel AHB-to-IOP bridge: one AHB slave port fanned out to NUM_CH
// IOP peripherals, with per-channel IOREADY wait states and a two-cycle
// ERROR response for unmapped channels.
// Optional feature: define CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN to add a wait-state
// watchdog (parameter TIMEOUT) that turns a stuck IOREADY into an ERROR.
//
//  state  | meaning
//  IDLE   | no data phase in progress, ready
//  ACCESS | data phase to channel ch_reg, waits on IOREADY[ch_reg]
//  ERR1   | first ERROR cycle (HREADYOUT=0, HRESP=1)
//  ERR2   | second ERROR cycle (HREADYOUT=1, HRESP=1), may accept
module cmsdk_ahb_to_iop_mc #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int CH_LSB     = 12
`ifdef CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  cmsdk_ahb_to_iop_mc_if.slave   bus
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

  state_t                  state, state_nxt;
  logic [CH_BITS-1:0]      ch_addr, ch_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    write_reg;
  logic [1:0]              size_reg;
  logic                    ch_ok;
  logic                    ready_sel;
  logic [31:0]             rdata_sel;
  logic [NUM_CH-1:0]       sel_dec;
  logic                    hreadyout_int;
  logic                    hresp_int;
  logic                    accept;
  logic                    timeout_hit;
  logic                    unused_bits;

  assign ch_addr     = bus.HADDR[CH_LSB +: CH_BITS];
  assign ch_ok       = int'(ch_addr) < NUM_CH;
  assign unused_bits = ^{bus.HADDR, bus.HTRANS[0], bus.HSIZE[2]};

  // Select ready, read data and one-hot select of the registered channel
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    sel_dec   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_reg == CH_BITS'(i)) begin
        ready_sel  = bus.IOREADY[i];
        rdata_sel  = bus.IORDATA[i*32 +: 32];
        sel_dec[i] = 1'b1;
      end
    end
  end

`ifdef CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  // Count IOREADY-low cycles of the current access; a new accept restarts it
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS && !ready_sel) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Bus responses, address-phase accept and next state
  always_comb begin
    hreadyout_int = 1'b1;
    hresp_int     = 1'b0;
    case (state)
      ST_ACCESS: hreadyout_int = ready_sel;
      ST_ERR1: begin
        hreadyout_int = 1'b0;
        hresp_int     = 1'b1;
      end
      ST_ERR2:   hresp_int = 1'b1;
      default:   ;
    endcase

    // Only accept when this slave is ready, so held registers stay stable
    accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_int;

    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_nxt = ch_ok ? ST_ACCESS : ST_ERR1;
        else        state_nxt = ST_IDLE;
      end
      ST_ACCESS: begin
        if (ready_sel) begin
          if (accept) state_nxt = ch_ok ? ST_ACCESS : ST_ERR1;
          else        state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1:  state_nxt = ST_ERR2;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Address-phase capture; held through wait states and error cycles
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
      ch_reg    <= '0;
    end else if (accept) begin
      addr_reg  <= bus.HADDR[ADDR_WIDTH-1:0];
      write_reg <= bus.HWRITE;
      size_reg  <= bus.HSIZE[1:0];
      ch_reg    <= ch_addr;
    end
  end

  assign bus.HREADYOUT = hreadyout_int;
  assign bus.HRESP     = hresp_int;
  assign bus.IOSEL     = (state == ST_ACCESS) ? sel_dec : '0;
  assign bus.IOTRANS   = (state == ST_ACCESS);
  assign bus.IOADDR    = addr_reg;
  assign bus.IOWRITE   = write_reg;
  assign bus.IOSIZE    = size_reg;
  assign bus.HRDATA    = (state == ST_ACCESS && !write_reg) ? rdata_sel : 32'h0;
  assign bus.IOWDATA   = bus.HWDATA;

endmodule

// File: tb/tb_cmsdk_ahb_to_iop_mc.sv
// Testbench for the multi-channel AHB-to-IOP bridge. Three channels are
// instantiated so that channel 3 is unmapped and exercises the ERROR path.
module tb_cmsdk_ahb_to_iop_mc;
  localparam int NCH = 3;
  localparam int AW  = 12;
  localparam int TO  = 8;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  cmsdk_ahb_to_iop_mc_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) bus ();

  cmsdk_ahb_to_iop_mc #(
    .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_LSB(12)
`ifdef CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .HCLK(hclk), .HRESET(hreset), .bus(bus)
  );

  // Single-slave system: the mux feeds our own HREADYOUT back as HREADY
  assign bus.HREADY = bus.HREADYOUT;

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input int ch, input logic [11:0] lo, input logic wr, input logic [2:0] sz);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    bus.HADDR  = $urandom();
    bus.HADDR[11:0]  = lo;
    bus.HADDR[13:12] = 2'(ch);
  endtask

  task automatic drive_idle();
    bus.HSEL   = 1'($urandom_range(0, 1));
    bus.HTRANS = bus.HSEL ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    bus.HWRITE = 1'($urandom_range(0, 1));
    bus.HSIZE  = 3'($urandom_range(0, 7));
    bus.HADDR  = $urandom();
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    drive_addr(1, 12'h123, 1'b1, 3'b010);
    bus.IOREADY = '1;
    bus.IORDATA = {$urandom(), $urandom(), $urandom()};
    bus.HWDATA  = $urandom();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS} !== 3'b100) begin
      failures++;
      $display("FAIL reset_resp: got %b want 100", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS});
    end
    checks++;
    if ({bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOSIZE, bus.HRDATA} !== '0) begin
      failures++;
      $display("FAIL reset_io: sel=%b addr=%h wr=%b sz=%b rd=%h want all zero",
               bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOSIZE, bus.HRDATA);
    end
    tick();
    hreset = 1'b0;
    drive_idle();
  endtask

  task automatic test_write_ch2();
    logic [31:0] wd;
    tick();
    drive_addr(2, 12'h04C, 1'b1, 3'b010);
    bus.IOREADY = '1;
    tick();
    drive_idle();
    wd = $urandom();
    bus.HWDATA = wd;
    @(negedge hclk);
    checks++;
    if (bus.IOSEL !== 3'b100) begin
      failures++;
      $display("FAIL wr_iosel: got %b want 100", bus.IOSEL);
    end
    checks++;
    if ({bus.IOADDR, bus.IOWRITE, bus.IOSIZE} !== {12'h04C, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL wr_ioregs: addr=%h wr=%b sz=%b want 04c 1 10", bus.IOADDR, bus.IOWRITE, bus.IOSIZE);
    end
    checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.HRDATA, bus.IOWDATA} !== {3'b101, 32'h0, wd}) begin
      failures++;
      $display("FAIL wr_resp: rdy/resp/trans=%b rd=%h wdata=%h want 101 0 %h",
               {bus.HREADYOUT, bus.HRESP, bus.IOTRANS}, bus.HRDATA, bus.IOWDATA, wd);
    end
    tick();
    @(negedge hclk);
    checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL} !== 6'b100000) begin
      failures++;
      $display("FAIL wr_after: got %b want 100000", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL});
    end
  endtask

  task automatic test_read_wait();
    logic [11:0] lo;
    int done_at;
    lo = 12'($urandom());
    tick();
    drive_addr(1, lo, 1'b0, 3'b001);
    bus.IOREADY = '1;
    done_at = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      // A stray address during the wait must not disturb the held access
      if (c < 3) drive_addr(0, 12'($urandom()), 1'b1, 3'b000);
      else       drive_idle();
      bus.IOREADY    = 3'b101;
      bus.IOREADY[1] = (c >= 3);
      bus.IORDATA    = {$urandom(), 32'hA5A5_1234, $urandom()};
      @(negedge hclk);
      checks++;
      if ({bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOTRANS, bus.HRESP} !== {3'b010, lo, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL rd_hold: sel=%b addr=%h wr=%b trans=%b resp=%b want 010 %h 0 1 0",
                 bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOTRANS, bus.HRESP, lo);
      end
      if (bus.HREADYOUT === 1'b1) begin
        done_at = c;
        break;
      end
    end
    checks++;
    if (done_at != 3) begin
      failures++;
      $display("FAIL rd_waits: got %0d want 3", done_at);
    end
    checks++;
    if (bus.HRDATA !== 32'hA5A5_1234) begin
      failures++;
      $display("FAIL rd_data: got %h want a5a51234", bus.HRDATA);
    end
    tick();
    bus.IOREADY = '1;
  endtask

  task automatic test_error();
    logic [31:0] rd;
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      drive_addr(3, 12'($urandom()), 1'($urandom_range(0, 1)), 3'b010);
      tick();
      drive_idle();
      @(negedge hclk);
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL} !== 6'b010000) begin
        failures++;
        $display("FAIL err1: got %b want 010000", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL});
      end
      tick();
      if (pass == 1) drive_addr(0, 12'h0A8, 1'b0, 3'b010);
      @(negedge hclk);
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL} !== 6'b110000) begin
        failures++;
        $display("FAIL err2: got %b want 110000", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL});
      end
      tick();
      drive_idle();
      rd = $urandom();
      bus.IORDATA = {$urandom(), $urandom(), rd};
      @(negedge hclk);
      checks++;
      if (pass == 0) begin
        if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL} !== 6'b100000) begin
          failures++;
          $display("FAIL err_idle: got %b want 100000", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL});
        end
      end else begin
        if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL, bus.IOADDR, bus.HRDATA} !==
            {4'b1010, 2'b01, 12'h0A8, rd}) begin
          failures++;
          $display("FAIL err2_accept: flags=%b sel=%b addr=%h rd=%h want 101 001 0a8 %h",
                   {bus.HREADYOUT, bus.HRESP, bus.IOTRANS}, bus.IOSEL, bus.IOADDR, bus.HRDATA, rd);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] a0, a1;
    logic [95:0] rdv;
    a0 = 12'($urandom());
    a1 = 12'($urandom());
    rdv = {$urandom(), $urandom(), $urandom()};
    tick();
    drive_addr(0, a0, 1'b0, 3'b010);
    bus.IOREADY = '1;
    bus.IORDATA = rdv;
    tick();
    drive_addr(2, a1, 1'b1, 3'b000);
    @(negedge hclk);
    checks++;
    if ({bus.IOSEL, bus.IOADDR, bus.HREADYOUT, bus.HRDATA} !== {3'b001, a0, 1'b1, rdv[31:0]}) begin
      failures++;
      $display("FAIL b2b_first: sel=%b addr=%h rdy=%b rd=%h want 001 %h 1 %h",
               bus.IOSEL, bus.IOADDR, bus.HREADYOUT, bus.HRDATA, a0, rdv[31:0]);
    end
    tick();
    drive_idle();
    @(negedge hclk);
    checks++;
    if ({bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOTRANS, bus.HRDATA} !== {3'b100, a1, 2'b11, 32'h0}) begin
      failures++;
      $display("FAIL b2b_second: sel=%b addr=%h wr=%b trans=%b rd=%h want 100 %h 1 1 0",
               bus.IOSEL, bus.IOADDR, bus.IOWRITE, bus.IOTRANS, bus.HRDATA, a1);
    end
    tick();
    @(negedge hclk);
    checks++;
    if ({bus.IOSEL, bus.IOTRANS} !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_end: got %b want 0000", {bus.IOSEL, bus.IOTRANS});
    end
  endtask

`ifdef CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN
  task automatic test_timeout();
    int stall;
    int done_at;
    bit got_err;
    // IOREADY[0] stuck low: TO wait cycles, then ERR1, ERR2, IDLE
    tick();
    drive_addr(0, 12'h010, 1'b0, 3'b010);
    bus.IOREADY = '1;
    stall = 0;
    got_err = 1'b0;
    for (int c = 0; c < TO + 10; c++) begin
      tick();
      drive_idle();
      bus.IOREADY = 3'b110;
      @(negedge hclk);
      if (bus.HRESP === 1'b1) begin
        got_err = 1'b1;
        break;
      end
      if (bus.HREADYOUT === 1'b0) stall++;
    end
    checks++;
    if (!got_err || stall != TO) begin
      failures++;
      $display("FAIL to_stuck: err=%0d waits=%0d want 1 %0d", got_err, stall, TO);
    end
    checks++;
    if ({bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL} !== 6'b010000) begin
      failures++;
      $display("FAIL to_err1: got %b want 010000", {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL});
    end
    tick();
    @(negedge hclk);
    checks++;
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b11) begin
      failures++;
      $display("FAIL to_err2: got %b want 11", {bus.HREADYOUT, bus.HRESP});
    end
    // IOREADY rises on the last allowed cycle: OKAY completion
    tick();
    drive_addr(0, 12'h020, 1'b0, 3'b010);
    bus.IOREADY = '1;
    done_at = -1;
    for (int c = 0; c < TO + 10; c++) begin
      tick();
      drive_idle();
      bus.IOREADY = (c >= TO - 1) ? 3'b111 : 3'b110;
      bus.IORDATA = {64'h0, 32'h600D_0008};
      @(negedge hclk);
      if (bus.HRESP === 1'b1 || bus.HREADYOUT === 1'b1) begin
        done_at = c;
        break;
      end
    end
    checks++;
    if (done_at != TO - 1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h600D_0008) begin
      failures++;
      $display("FAIL to_ok: done=%0d resp=%b rd=%h want %0d 0 600d0008", done_at, bus.HRESP, bus.HRDATA, TO - 1);
    end
    tick();
    bus.IOREADY = '1;
  endtask
`endif

  task automatic test_random();
    bit act = 1'b0, err = 1'b0;
    int errc = 0, cch = 0, cw = 0;
    logic [11:0] caddr = '0;
    logic cwr = 1'b0;
    logic [1:0] csz = '0;
    bit new_req;
    int nch;
    logic [11:0] naddr;
    logic nwr;
    logic [2:0] nsz;
    logic [NCH-1:0] io;
    logic [95:0] rdv;
    logic [1+1+1+NCH+32-1:0] exp_v, obs_v;
    bit exp_rdy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      io = NCH'($urandom());
      if (act && !err) io[cch] = (cw == 0);
      bus.IOREADY = io;
      rdv = {$urandom(), $urandom(), $urandom()};
      bus.IORDATA = rdv;
      bus.HWDATA  = $urandom();
      new_req = ($urandom_range(0, 2) != 0);
      nch   = $urandom_range(0, 3);
      naddr = 12'($urandom());
      nwr   = 1'($urandom_range(0, 1));
      nsz   = 3'($urandom_range(0, 7));
      if (new_req) drive_addr(nch, naddr, nwr, nsz);
      else         drive_idle();

      if (act && !err) begin
        exp_rdy = (cw == 0);
        exp_v = {exp_rdy, 1'b0, 1'b1, NCH'(1) << cch, cwr ? 32'h0 : rdv[cch*32 +: 32]};
      end else if (act) begin
        exp_rdy = (errc == 1);
        exp_v = {exp_rdy, 1'b1, 1'b0, NCH'(0), 32'h0};
      end else begin
        exp_rdy = 1'b1;
        exp_v = {1'b1, 1'b0, 1'b0, NCH'(0), 32'h0};
      end

      @(negedge hclk);
      obs_v = {bus.HREADYOUT, bus.HRESP, bus.IOTRANS, bus.IOSEL, bus.HRDATA};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL rand_cycle%0d: rdy/resp/trans/sel/rd got %h want %h", cyc, obs_v, exp_v);
      end
      if (act && !err) begin
        checks++;
        if ({bus.IOADDR, bus.IOWRITE, bus.IOSIZE} !== {caddr, cwr, csz}) begin
          failures++;
          $display("FAIL rand_ioregs%0d: got %h/%b/%b want %h/%b/%b", cyc,
                   bus.IOADDR, bus.IOWRITE, bus.IOSIZE, caddr, cwr, csz);
        end
      end

      if (exp_rdy) begin
        if (new_req) begin
          act = 1'b1;
          err = (nch >= NCH);
          errc = 0;
          cch = nch;
          cw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
          caddr = naddr;
          cwr = nwr;
          csz = nsz[1:0];
        end else begin
          act = 1'b0;
        end
      end else if (err) begin
        errc++;
      end else begin
        cw--;
      end
    end
    tick();
    drive_idle();
    bus.IOREADY = '1;
    repeat (6) tick();
  endtask

  initial begin
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HSIZE = 3'b000;
    bus.HWRITE = 1'b0;
    bus.HADDR = '0;
    bus.HWDATA = '0;
    bus.IORDATA = '0;
    bus.IOREADY = '1;
    test_reset();
    test_write_ch2();
    test_read_wait();
    test_error();
    test_back_to_back();
`ifdef CMSDK_AHB_TO_IOP_MC_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
